// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters for the 5-stage pipeline.
// Stalls ID while a source register still has an unsatisfied pending write.
module reg_scoreboard #(
   parameter int unsigned CNT_W        = 2,
   parameter int unsigned MAX_INFLIGHT = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       issue_id,
   input  logic       reg_write_id,
   input  logic [4:0] reg_w_addr_id,
   input  logic [4:0] rs_addr_id,
   input  logic [4:0] rt_addr_id,
   input  logic       rs_used_id,
   input  logic       rt_used_id,
   input  logic       kill_ex,
   input  logic       reg_write_ex,
   input  logic [4:0] reg_w_addr_ex,
   input  logic       reg_write_wb,
   input  logic [4:0] reg_w_addr_wb,
   output logic       stall,
   output logic       busy,
   output logic       overflow,
   output logic       underflow
);

   localparam int unsigned NREG = 32;
   // Two extra bits hold the signed net result (range -2 .. MAX_INFLIGHT+1).
   localparam int unsigned SW   = CNT_W + 2;

   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic [NREG-1:0][CNT_W-1:0] cnt_nxt;
   logic [NREG-1:0]            inc_hit;
   logic [NREG-1:0]            dec_k_hit;
   logic [NREG-1:0]            dec_w_hit;
   logic [SW-1:0]              rs_left;
   logic [SW-1:0]              rt_left;
   logic                       rs_pend;
   logic                       rt_pend;
   logic [SW-1:0]              sum;
   logic                       ov_set;
   logic                       un_set;

   // Decrement one-hots; register 0 is never touched.
   always_comb begin
      dec_k_hit = '0;
      dec_w_hit = '0;
      if (kill_ex && reg_write_ex) dec_k_hit[reg_w_addr_ex] = 1'b1;
      if (reg_write_wb)            dec_w_hit[reg_w_addr_wb] = 1'b1;
      dec_k_hit[0] = 1'b0;
      dec_w_hit[0] = 1'b0;
   end

   // Same-cycle WB retirement (write-first regfile) and squash both relieve a source.
   always_comb begin
      rs_left = SW'(cnt[rs_addr_id]) - SW'(dec_w_hit[rs_addr_id]) - SW'(dec_k_hit[rs_addr_id]);
      rt_left = SW'(cnt[rt_addr_id]) - SW'(dec_w_hit[rt_addr_id]) - SW'(dec_k_hit[rt_addr_id]);
      rs_pend = rs_used_id && (rs_addr_id != 5'd0) && !rs_left[SW-1] && (rs_left != '0);
      rt_pend = rt_used_id && (rt_addr_id != 5'd0) && !rt_left[SW-1] && (rt_left != '0);
      stall   = rs_pend || rt_pend;
   end

   assign busy = |cnt;

   // Net per-register update with saturation and clamp.
   always_comb begin
      inc_hit = '0;
      cnt_nxt = cnt;
      sum     = '0;
      ov_set  = 1'b0;
      un_set  = 1'b0;
      if (issue_id && !stall && reg_write_id) inc_hit[reg_w_addr_id] = 1'b1;
      inc_hit[0] = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         sum = SW'(cnt[i]) + SW'(inc_hit[i]) - SW'(dec_k_hit[i]) - SW'(dec_w_hit[i]);
         if (sum[SW-1]) begin
            un_set     = 1'b1;
            cnt_nxt[i] = '0;
         end else if (sum > SW'(MAX_INFLIGHT)) begin
            ov_set     = 1'b1;
            cnt_nxt[i] = CNT_W'(MAX_INFLIGHT);
         end else begin
            cnt_nxt[i] = sum[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         overflow  <= overflow | ov_set;
         underflow <= underflow | un_set;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against an
// array-of-integers reference model of the in-flight counts.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_id, reg_write_id;
   logic [4:0] reg_w_addr_id, rs_addr_id, rt_addr_id;
   logic       rs_used_id, rt_used_id;
   logic       kill_ex, reg_write_ex;
   logic [4:0] reg_w_addr_ex;
   logic       reg_write_wb;
   logic [4:0] reg_w_addr_wb;
   logic       stall, busy, overflow, underflow;

   int m_cnt[32];
   bit m_ov, m_un;
   int n_vec = 0;
   int n_err = 0;

   reg_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(3)) dut (
      .clk(clk), .rst(rst),
      .issue_id(issue_id), .reg_write_id(reg_write_id), .reg_w_addr_id(reg_w_addr_id),
      .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
      .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
      .kill_ex(kill_ex), .reg_write_ex(reg_write_ex), .reg_w_addr_ex(reg_w_addr_ex),
      .reg_write_wb(reg_write_wb), .reg_w_addr_wb(reg_w_addr_wb),
      .stall(stall), .busy(busy), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A source is pending if its count, minus same-cycle retirement and squash, is positive.
   function automatic bit m_pend(input bit used, input logic [4:0] a);
      int left;
      if (!used || a == 5'd0) return 1'b0;
      left = m_cnt[a];
      if (reg_write_wb && reg_w_addr_wb == a) left--;
      if (kill_ex && reg_write_ex && reg_w_addr_ex == a) left--;
      return left > 0;
   endfunction

   task automatic idle_inputs();
      rst = 1'b0; issue_id = 1'b0; reg_write_id = 1'b0; reg_w_addr_id = '0;
      rs_addr_id = '0; rt_addr_id = '0; rs_used_id = 1'b0; rt_used_id = 1'b0;
      kill_ex = 1'b0; reg_write_ex = 1'b0; reg_w_addr_ex = '0;
      reg_write_wb = 1'b0; reg_w_addr_wb = '0;
   endtask

   // One clock: check stall mid-cycle, advance model at the edge, check state after.
   task automatic cyc(input int want_stall = -1);
      bit exp_stall, any;
      int d[32];
      int v;
      @(negedge clk);
      exp_stall = m_pend(rs_used_id, rs_addr_id) | m_pend(rt_used_id, rt_addr_id);
      check("stall", 32'(stall), 32'(exp_stall));
      if (want_stall >= 0) check("stall_dir", 32'(stall), 32'(want_stall));
      @(posedge clk);
      if (rst) begin
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_ov = 1'b0;
         m_un = 1'b0;
      end else begin
         foreach (d[i]) d[i] = 0;
         if (issue_id && !exp_stall && reg_write_id) d[reg_w_addr_id]++;
         if (kill_ex && reg_write_ex) d[reg_w_addr_ex]--;
         if (reg_write_wb) d[reg_w_addr_wb]--;
         d[0] = 0;
         for (int i = 1; i < 32; i++) begin
            v = m_cnt[i] + d[i];
            if (v > 3) begin m_ov = 1'b1; v = 3; end
            if (v < 0) begin m_un = 1'b1; v = 0; end
            m_cnt[i] = v;
         end
      end
      #1;
      any = 1'b0;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) any = 1'b1;
      check("busy", 32'(busy), 32'(any));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("underflow", 32'(underflow), 32'(m_un));
   endtask

   task automatic issue_wr(input logic [4:0] a);
      idle_inputs();
      issue_id = 1'b1; reg_write_id = 1'b1; reg_w_addr_id = a;
   endtask

   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ov = 1'b0;
      m_un = 1'b0;
      idle_inputs();

      // Reset held two cycles with random activity
      for (int k = 0; k < 2; k++) begin
         {issue_id, reg_write_id, kill_ex, reg_write_ex, reg_write_wb} = 5'($urandom);
         {reg_w_addr_id, rs_addr_id, rt_addr_id} = 15'($urandom);
         rst = 1'b1;
         cyc();
      end
      idle_inputs();
      cyc(0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_flags", 32'({overflow, underflow}), 32'd0);

      // Basic RAW on r5: two stall cycles, released by WB write-first
      issue_wr(5'd5); cyc(0);
      idle_inputs(); issue_id = 1'b1; rs_used_id = 1'b1; rs_addr_id = 5'd5;
      cyc(1);
      cyc(1);
      reg_write_wb = 1'b1; reg_w_addr_wb = 5'd5;
      cyc(0);
      check("raw_busy", 32'(busy), 32'd0);

      // r0 immunity
      for (int k = 0; k < 3; k++) begin issue_wr(5'd0); cyc(0); end
      idle_inputs(); issue_id = 1'b1; rs_used_id = 1'b1; rt_used_id = 1'b1;
      cyc(0);
      check("r0_busy", 32'(busy), 32'd0);
      check("r0_ovf", 32'(overflow), 32'd0);

      // Squash of r7 writer relieves the same-cycle reader
      issue_wr(5'd7); cyc(0);
      idle_inputs(); issue_id = 1'b1; rs_used_id = 1'b1; rs_addr_id = 5'd7;
      kill_ex = 1'b1; reg_write_ex = 1'b1; reg_w_addr_ex = 5'd7;
      cyc(0);
      idle_inputs(); cyc(0);
      check("sq_busy", 32'(busy), 32'd0);
      check("sq_unf", 32'(underflow), 32'd0);

      // Simultaneous inc and WB dec on r9 keeps count at 1
      issue_wr(5'd9); cyc(0);
      issue_wr(5'd9); reg_write_wb = 1'b1; reg_w_addr_wb = 5'd9; cyc(0);
      idle_inputs(); issue_id = 1'b1; rt_used_id = 1'b1; rt_addr_id = 5'd9;
      cyc(1);
      idle_inputs(); reg_write_wb = 1'b1; reg_w_addr_wb = 5'd9; cyc(0);
      idle_inputs(); cyc(0);
      check("sim_busy", 32'(busy), 32'd0);

      // Saturation on r3, then drain and underflow
      for (int k = 0; k < 4; k++) begin issue_wr(5'd3); cyc(0); end
      check("sat_ovf", 32'(overflow), 32'd1);
      for (int k = 0; k < 3; k++) begin
         idle_inputs(); reg_write_wb = 1'b1; reg_w_addr_wb = 5'd3; cyc(0);
      end
      check("sat_drained", 32'(busy), 32'd0);
      check("sat_no_unf", 32'(underflow), 32'd0);
      cyc(0);
      check("sat_unf", 32'(underflow), 32'd1);
      idle_inputs(); cyc(0); cyc(0);
      check("sticky", 32'({overflow, underflow}), 32'd3);
      rst = 1'b1; cyc(0);
      idle_inputs(); cyc(0);
      check("sticky_clr", 32'({overflow, underflow}), 32'd0);

      // Random traffic over a small register window to force collisions
      for (int k = 0; k < 3000; k++) begin
         idle_inputs();
         rst           = ($urandom_range(0, 99) == 0);
         issue_id      = 1'($urandom);
         reg_write_id  = 1'($urandom);
         reg_w_addr_id = 5'($urandom_range(0, 7));
         rs_addr_id    = 5'($urandom_range(0, 7));
         rt_addr_id    = 5'($urandom_range(0, 7));
         rs_used_id    = 1'($urandom);
         rt_used_id    = 1'($urandom);
         kill_ex       = ($urandom_range(0, 5) == 0);
         reg_write_ex  = 1'($urandom);
         reg_w_addr_ex = 5'($urandom_range(0, 7));
         reg_write_wb  = ($urandom_range(0, 2) == 0);
         reg_w_addr_wb = 5'($urandom_range(0, 7));
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
